// File: rtl/lattice_scanner.sv
`default_nettype none
// ============================================================================
// lattice_scanner : raster-scans an FHP lattice memory into a VGA pixel buffer
// Revision 1.0
// ============================================================================
module lattice_scanner #(
  parameter int LAT_W    = 160,
  parameter int LAT_H    = 120,
  parameter int ADDR_W   = 15,
  parameter int READ_LAT = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic [ADDR_W-1:0] cell_addr,
  input  logic [5:0]        cell_rdata,
  output logic [5:0]        cell_state,
  output logic [9:0]        pix_x,
  output logic [8:0]        pix_y,
  output logic              pix_write,
  input  logic              pix_waitrequest,
  output logic              busy,
  output logic              frame_done
);

  localparam int LAT_CW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [9:0]        X_LAST   = 10'(LAT_W - 1);
  localparam logic [8:0]        Y_LAST   = 9'(LAT_H - 1);
  localparam logic [LAT_CW-1:0] LAT_LAST = LAT_CW'(READ_LAT - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [9:0]          x_q, x_d;
  logic [8:0]          y_q, y_d;
  logic [LAT_CW-1:0]   lat_q, lat_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [5:0]          cstate_q, cstate_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      lat_q    <= '0;
      addr_q   <= '0;
      cstate_q <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      lat_q    <= lat_d;
      addr_q   <= addr_d;
      cstate_q <= cstate_d;
    end
  end

  // Raster order makes y*LAT_W+x a plain running count, so the address
  // advances by one per accepted write instead of needing a multiplier.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    lat_d    = lat_q;
    addr_d   = addr_q;
    cstate_d = cstate_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ADDR;
          x_d     = '0;
          y_d     = '0;
          addr_d  = '0;
        end
      end
      ST_ADDR: begin
        lat_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (lat_q == LAT_LAST) begin
          cstate_d = cell_rdata;
          state_d  = ST_WRITE;
        end else begin
          lat_d = lat_q + LAT_CW'(1);
        end
      end
      ST_WRITE: begin
        if (!pix_waitrequest) begin
          if (x_q != X_LAST) begin
            x_d     = x_q + 10'd1;
            addr_d  = addr_q + ADDR_W'(1);
            state_d = ST_ADDR;
          end else if (y_q != Y_LAST) begin
            x_d     = '0;
            y_d     = y_q + 9'd1;
            addr_d  = addr_q + ADDR_W'(1);
            state_d = ST_ADDR;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign cell_addr  = addr_q;
  assign cell_state = cstate_q;
  assign pix_x      = x_q;
  assign pix_y      = y_q;
  assign pix_write  = (state_q == ST_WRITE);
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_lattice_scanner.sv
`default_nettype none
// ============================================================================
// tb_lattice_scanner : randomized scenarios against a raster-order frame model
// Revision 1.0
// ============================================================================
module tb_lattice_scanner;

  localparam int AW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, start, wreq, sel;
  logic start_a, start_b;
  assign start_a = start & ~sel;
  assign start_b = start & sel;

  logic [AW-1:0] addr_a, addr_b;
  logic [5:0]    rdata_a, rdata_b, state_a, state_b;
  logic [9:0]    px_a, px_b;
  logic [8:0]    py_a, py_b;
  logic          pw_a, pw_b, busy_a, busy_b, fd_a, fd_b;

  // Instance A: 4x2 lattice, 2-cycle memory. Instance B: 5x3 lattice, 1-cycle memory.
  lattice_scanner #(.LAT_W(4), .LAT_H(2), .ADDR_W(AW), .READ_LAT(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .cell_addr(addr_a),
    .cell_rdata(rdata_a), .cell_state(state_a), .pix_x(px_a), .pix_y(py_a),
    .pix_write(pw_a), .pix_waitrequest(wreq), .busy(busy_a), .frame_done(fd_a));

  lattice_scanner #(.LAT_W(5), .LAT_H(3), .ADDR_W(AW), .READ_LAT(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .cell_addr(addr_b),
    .cell_rdata(rdata_b), .cell_state(state_b), .pix_x(px_b), .pix_y(py_b),
    .pix_write(pw_b), .pix_waitrequest(wreq), .busy(busy_b), .frame_done(fd_b));

  logic [5:0] mem_a [64];
  logic [5:0] mem_b [64];
  logic [5:0] pa0, pa1, pb0;
  always @(posedge clk) begin
    pa0 <= mem_a[addr_a];
    pa1 <= pa0;
    pb0 <= mem_b[addr_b];
  end
  assign rdata_a = pa1;
  assign rdata_b = pb0;

  logic [AW-1:0] s_addr;
  logic [5:0]    s_state;
  logic [9:0]    s_px;
  logic [8:0]    s_py;
  logic          s_pw, s_busy, s_fd;
  assign s_addr  = sel ? addr_b  : addr_a;
  assign s_state = sel ? state_b : state_a;
  assign s_px    = sel ? px_b    : px_a;
  assign s_py    = sel ? py_b    : py_a;
  assign s_pw    = sel ? pw_b    : pw_a;
  assign s_busy  = sel ? busy_b  : busy_a;
  assign s_fd    = sel ? fd_b    : fd_a;

  int errors = 0;
  int checks = 0;

  // Runs one frame on the selected instance. Entered just after a rising edge.
  // Cycle k is the interval after the k-th edge counting the start edge as 0.
  task automatic do_scan(input int pct, input int targ, input int targ_n,
                         input bit hold, output int done_cyc);
    int rl, w, h, n, idx, stalls, used, k, exp_c;
    bit newc, done, ok;
    logic [5:0] expd;
    logic [AW-1:0] ah [512];
    rl = sel ? 1 : 2;
    w  = sel ? 5 : 4;
    h  = sel ? 3 : 2;
    n  = w * h;
    idx = 0; stalls = 0; used = 0; k = 1; newc = 1'b1; done = 1'b0;
    done_cyc = -1;
    start = 1'b1;
    wreq  = 1'b0;
    @(posedge clk); #1;
    start = hold;
    while (!done && k < 500) begin
      wreq = 1'b0;
      if (s_pw === 1'b1) begin
        if (idx == targ && used < targ_n) begin
          wreq = 1'b1;
          used++;
        end else if (int'($urandom_range(0, 99)) < pct) begin
          wreq = 1'b1;
        end
      end
      @(negedge clk);
      ah[k] = s_addr;
      checks++;
      if (s_busy !== 1'b1) begin
        errors++;
        $display("FAIL busy_in_scan cyc=%0d got=%b want=1", k, s_busy);
      end
      if (s_fd === 1'b1) begin
        exp_c = 1 + n * (2 + rl) + stalls;
        checks++;
        if (idx != n || k != exp_c) begin
          errors++;
          $display("FAIL frame_done cyc=%0d cells=%0d want cyc=%0d cells=%0d", k, idx, exp_c, n);
        end
        done = 1'b1;
        done_cyc = k;
      end else if (s_pw === 1'b1) begin
        if (idx >= n) begin
          checks++;
          errors++;
          $display("FAIL extra_write cyc=%0d x=%0d y=%0d want no write", k, s_px, s_py);
        end else begin
          if (newc) begin
            exp_c = 1 + idx * (2 + rl) + stalls + 1 + rl;
            checks++;
            if (k != exp_c) begin
              errors++;
              $display("FAIL write_timing cell=%0d cyc=%0d want=%0d", idx, k, exp_c);
            end
            ok = 1'b1;
            for (int j = 1; j <= rl + 1; j++)
              if (k - j >= 1 && ah[k - j] !== AW'(idx)) ok = 1'b0;
            checks++;
            if (!ok) begin
              errors++;
              $display("FAIL addr_hold cell=%0d last_addr=%0d want=%0d", idx, ah[k - 1], idx);
            end
          end
          expd = sel ? mem_b[idx] : mem_a[idx];
          checks++;
          if (s_px !== 10'(idx % w) || s_py !== 9'(idx / w) || s_state !== expd) begin
            errors++;
            $display("FAIL write_data cell=%0d got x=%0d y=%0d st=%h want x=%0d y=%0d st=%h",
                     idx, s_px, s_py, s_state, idx % w, idx / w, expd);
          end
          if (wreq) begin
            stalls++;
            newc = 1'b0;
          end else begin
            idx++;
            newc = 1'b1;
          end
        end
      end
      if (!done) begin
        @(posedge clk); #1;
        k++;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL scan_timeout cells=%0d want frame_done", idx);
    end
    wreq = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (s_busy !== 1'b0 || s_fd !== 1'b0 || s_pw !== 1'b0) begin
      errors++;
      $display("FAIL after_done busy=%b fd=%b pw=%b want 0 0 0", s_busy, s_fd, s_pw);
    end
  endtask

  task automatic test_reset();
    sel = 1'b0; start = 1'b0; wreq = 1'b0; reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (s_addr !== '0 || s_state !== '0 || s_px !== '0 || s_py !== '0 ||
        s_pw !== 1'b0 || s_busy !== 1'b0 || s_fd !== 1'b0) begin
      errors++;
      $display("FAIL reset_a addr=%0d st=%h x=%0d y=%0d pw=%b busy=%b fd=%b want all 0",
               s_addr, s_state, s_px, s_py, s_pw, s_busy, s_fd);
    end
    sel = 1'b1;
    #1;
    checks++;
    if (s_addr !== '0 || s_state !== '0 || s_pw !== 1'b0 || s_busy !== 1'b0 || s_fd !== 1'b0) begin
      errors++;
      $display("FAIL reset_b addr=%0d st=%h pw=%b busy=%b fd=%b want all 0",
               s_addr, s_state, s_pw, s_busy, s_fd);
    end
    sel = 1'b0;
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (s_busy !== 1'b0 || s_pw !== 1'b0) begin
      errors++;
      $display("FAIL start_in_reset busy=%b pw=%b want 0 0", s_busy, s_pw);
    end
    start = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    int dc;
    sel = 1'b0;
    for (int i = 0; i < 64; i++) mem_a[i] = 6'(i);
    do_scan(0, -1, 0, 1'b0, dc);
    checks++;
    if (dc != 33) begin
      errors++;
      $display("FAIL basic_done_cycle got=%0d want=33", dc);
    end
  endtask

  task automatic test_stall();
    int dc;
    sel = 1'b0;
    for (int i = 0; i < 64; i++) mem_a[i] = 6'(i);
    do_scan(0, 2, 3, 1'b0, dc);
    checks++;
    if (dc != 36) begin
      errors++;
      $display("FAIL stall_done_cycle got=%0d want=36", dc);
    end
  endtask

  task automatic test_random_stall();
    int dc;
    sel = 1'b0;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 64; i++) mem_a[i] = 6'($urandom);
      do_scan(40, -1, 0, 1'b0, dc);
    end
  endtask

  task automatic test_back_to_back();
    int dc1, dc2;
    sel = 1'b0;
    for (int i = 0; i < 64; i++) mem_a[i] = 6'($urandom);
    do_scan(0, -1, 0, 1'b1, dc1);
    checks++;
    if (dc1 != 33) begin
      errors++;
      $display("FAIL held_start_done_cycle got=%0d want=33", dc1);
    end
    do_scan(20, -1, 0, 1'b0, dc2);
  endtask

  task automatic test_reset_abort();
    int dc;
    bit bad;
    sel = 1'b0;
    for (int i = 0; i < 64; i++) mem_a[i] = 6'($urandom);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (21) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (s_addr !== AW'(5) || s_busy !== 1'b1 || s_pw !== 1'b0) begin
      errors++;
      $display("FAIL pre_abort addr=%0d busy=%b pw=%b want 5 1 0", s_addr, s_busy, s_pw);
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (s_addr !== '0 || s_state !== '0 || s_px !== '0 || s_py !== '0 ||
        s_pw !== 1'b0 || s_busy !== 1'b0 || s_fd !== 1'b0) begin
      errors++;
      $display("FAIL async_abort addr=%0d st=%h x=%0d y=%0d pw=%b busy=%b fd=%b want all 0",
               s_addr, s_state, s_px, s_py, s_pw, s_busy, s_fd);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    bad = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (s_pw !== 1'b0 || s_fd !== 1'b0 || s_busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL post_abort_idle got activity want none");
    end
    @(posedge clk); #1;
    do_scan(0, -1, 0, 1'b0, dc);
    checks++;
    if (dc != 33) begin
      errors++;
      $display("FAIL rescan_done_cycle got=%0d want=33", dc);
    end
  endtask

  task automatic test_read_lat1();
    int dc;
    sel = 1'b1;
    for (int i = 0; i < 64; i++) mem_b[i] = 6'h3f;
    @(posedge clk); #1;
    do_scan(0, -1, 0, 1'b0, dc);
    checks++;
    if (dc != 46) begin
      errors++;
      $display("FAIL lat1_done_cycle got=%0d want=46", dc);
    end
    for (int i = 0; i < 64; i++) mem_b[i] = 6'($urandom);
    do_scan(30, -1, 0, 1'b0, dc);
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_random_stall();
    test_back_to_back();
    test_reset_abort();
    test_read_lat1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
